// File: rtl/idelay_eye_scan_ctrl.sv
// IDELAY eye scan: sweeps every tap on one ADC line, measures the widest
// window that returns the training pattern and loads the tap at its centre.
module idelay_eye_scan_ctrl #(
    parameter int                        DATA_WIDTH_ADC = 12,
    parameter int                        TAP_WIDTH      = 5,
    parameter logic [DATA_WIDTH_ADC-1:0] TRAIN_PATTERN  = 'h9C3,
    parameter int                        SETTLE_CYCLES  = 16,
    parameter int                        CHECK_SAMPLES  = 64,
    parameter int                        MIN_EYE        = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_calib_i,
    input  logic [7:0]                line_sel_i,
    input  logic [DATA_WIDTH_ADC-1:0] data_i,
    output logic                      idelay_ld_o,
    output logic [TAP_WIDTH-1:0]      idelay_tap_o,
    output logic [7:0]                idelay_line_o,
    output logic                      calibration_done_o,
    output logic                      calibration_not_done_o,
    output logic [TAP_WIDTH-1:0]      eye_start_o,
    output logic [TAP_WIDTH:0]        eye_width_o
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_SAMPLES) ? SETTLE_CYCLES : CHECK_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [TAP_WIDTH-1:0] TAP_LAST = '1;

    typedef enum logic [2:0] {
        IDLE, SET_TAP, SETTLE, CHECK, EVAL, CENTER, DONE, FAIL
    } state_t;

    state_t               state_q, state_d;
    logic                 en_q;
    logic                 start;
    logic                 busy;
    logic [TAP_WIDTH-1:0] tap_q;
    logic [TAP_WIDTH-1:0] tap_hold_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 fail_q;
    logic [TAP_WIDTH-1:0] cur_start_q, best_start_q, open_start;
    logic [TAP_WIDTH:0]   cur_len_q, best_len_q, open_len;
    logic [TAP_WIDTH-1:0] center_tap;
    logic                 settle_last, check_last, tap_last, eye_ok;

    assign start       = en_calib_i & ~en_q;
    assign busy        = (state_q == SET_TAP) || (state_q == SETTLE) || (state_q == CHECK) ||
                         (state_q == EVAL) || (state_q == CENTER);
    assign settle_last = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign check_last  = (cnt_q == CNT_W'(CHECK_SAMPLES - 1));
    assign tap_last    = (tap_q == TAP_LAST);
    assign eye_ok      = (best_len_q >= (TAP_WIDTH+1)'(MIN_EYE));
    // start + len/2 never exceeds the top tap, so dropping the carry bit is safe
    assign center_tap  = TAP_WIDTH'({1'b0, best_start_q} + (best_len_q >> 1));

    // The window that would be open after counting the current tap as a pass
    assign open_start  = (cur_len_q == '0) ? tap_q : cur_start_q;
    assign open_len    = cur_len_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        idelay_ld_o  = 1'b0;
        idelay_tap_o = tap_hold_q;
        case (state_q)
            IDLE:    if (start) state_d = SET_TAP;
            SET_TAP: begin
                idelay_ld_o  = 1'b1;
                idelay_tap_o = tap_q;
                state_d      = SETTLE;
            end
            SETTLE:  if (settle_last) state_d = CHECK;
            CHECK:   if (check_last) state_d = EVAL;
            EVAL:    state_d = tap_last ? CENTER : SET_TAP;
            CENTER: begin
                idelay_ld_o  = 1'b1;
                idelay_tap_o = eye_ok ? center_tap : '0;
                state_d      = eye_ok ? DONE : FAIL;
            end
            DONE, FAIL: if (!en_calib_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort: drop straight to IDLE and leave the primitive on its last tap
        if (busy && !en_calib_i) begin
            state_d      = IDLE;
            idelay_ld_o  = 1'b0;
            idelay_tap_o = tap_hold_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q                   <= 1'b0;
            tap_q                  <= '0;
            tap_hold_q             <= '0;
            cnt_q                  <= '0;
            fail_q                 <= 1'b0;
            cur_start_q            <= '0;
            cur_len_q              <= '0;
            best_start_q           <= '0;
            best_len_q             <= '0;
            idelay_line_o          <= '0;
            calibration_done_o     <= 1'b0;
            calibration_not_done_o <= 1'b0;
            eye_start_o            <= '0;
            eye_width_o            <= '0;
        end else begin
            en_q <= en_calib_i;
            if (idelay_ld_o) tap_hold_q <= idelay_tap_o;
            case (state_q)
                IDLE: if (start) begin
                    idelay_line_o          <= line_sel_i;
                    calibration_done_o     <= 1'b0;
                    calibration_not_done_o <= 1'b0;
                    eye_start_o            <= '0;
                    eye_width_o            <= '0;
                    tap_q                  <= '0;
                    cnt_q                  <= '0;
                    fail_q                 <= 1'b0;
                    cur_start_q            <= '0;
                    cur_len_q              <= '0;
                    best_start_q           <= '0;
                    best_len_q             <= '0;
                end
                SET_TAP: begin
                    cnt_q  <= '0;
                    fail_q <= 1'b0;
                end
                SETTLE: cnt_q <= settle_last ? '0 : cnt_q + 1'b1;
                CHECK: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Keep sampling after a miss so every tap costs the same time
                    if (data_i != TRAIN_PATTERN) fail_q <= 1'b1;
                end
                EVAL: if (en_calib_i) begin
                    if (!fail_q) begin
                        cur_start_q <= open_start;
                        cur_len_q   <= open_len;
                        if (tap_last && (open_len > best_len_q)) begin
                            best_start_q <= open_start;
                            best_len_q   <= open_len;
                        end
                    end else begin
                        if (cur_len_q > best_len_q) begin
                            best_start_q <= cur_start_q;
                            best_len_q   <= cur_len_q;
                        end
                        cur_len_q <= '0;
                    end
                    if (!tap_last) tap_q <= tap_q + 1'b1;
                end
                CENTER: if (en_calib_i) begin
                    eye_start_o            <= best_start_q;
                    eye_width_o            <= best_len_q;
                    calibration_done_o     <= eye_ok;
                    calibration_not_done_o <= ~eye_ok;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_idelay_eye_scan_ctrl.sv
// Bench for idelay_eye_scan_ctrl: emulates the IDELAY line from a per-tap pass
// mask and scoreboards each sweep result against a run-length eye model.
module tb_idelay_eye_scan_ctrl;

    localparam int DW = 12;
    localparam int TW = 5;
    localparam int NT = 32;
    localparam logic [DW-1:0] PAT = 12'h9C3;
    localparam int SETTLE = 16;
    localparam int CHECK = 64;
    localparam int MIN_EYE = 4;
    localparam int SWEEP_CYC = NT * (1 + SETTLE + CHECK + 1) + 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          en_calib_i = 1'b0;
    logic [7:0]    line_sel_i = '0;
    logic [DW-1:0] data_i = '0;
    logic          idelay_ld_o;
    logic [TW-1:0] idelay_tap_o;
    logic [7:0]    idelay_line_o;
    logic          calibration_done_o;
    logic          calibration_not_done_o;
    logic [TW-1:0] eye_start_o;
    logic [TW:0]   eye_width_o;

    idelay_eye_scan_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_calib_i(en_calib_i),
        .line_sel_i(line_sel_i), .data_i(data_i),
        .idelay_ld_o(idelay_ld_o), .idelay_tap_o(idelay_tap_o),
        .idelay_line_o(idelay_line_o), .calibration_done_o(calibration_done_o),
        .calibration_not_done_o(calibration_not_done_o),
        .eye_start_o(eye_start_o), .eye_width_o(eye_width_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int done; int nd; int st; int w; int tap; int line;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mask = '0;
    int          glitch[NT];
    int          strobes = 0;
    int          start_strobes = 0;
    int          first_tap = -1;
    int          first_cyc = 0;
    int          cyc = 0;
    int          since = 100000;
    int          cur_tap = 0;
    bit          flag_q = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Longest run of passing taps; the first of equal-length runs wins
    task automatic model(input logic [31:0] m, input int line);
        exp_t e;
        int t, s, st, w;
        st = 0; w = 0; t = 0;
        while (t < NT) begin
            if (m[t]) begin
                s = t;
                while (t < NT && m[t]) t++;
                if (t - s > w) begin w = t - s; st = s; end
            end else t++;
        end
        e.done = (w >= MIN_EYE) ? 1 : 0;
        e.nd   = 1 - e.done;
        e.st   = st;
        e.w    = w;
        e.tap  = e.done ? st + w / 2 : 0;
        e.line = line;
        sb_q.push_back(e);
    endtask

    // Line emulation (tap tracking, data drive) plus the result monitor
    initial forever begin
        exp_t e;
        bit flag;
        @(negedge clk_i);
        cyc++;
        if (idelay_ld_o) begin
            if (strobes == start_strobes) begin
                first_tap = int'(idelay_tap_o);
                first_cyc = cyc;
            end
            strobes++;
            cur_tap = int'(idelay_tap_o);
            since = -1;
        end else if (since < 100000) since++;

        if (since >= 0 && since < SETTLE)
            data_i = PAT ^ DW'($urandom_range(1, 4095));
        else if (since >= SETTLE && since < SETTLE + CHECK && !mask[cur_tap] &&
                 since - SETTLE == glitch[cur_tap])
            data_i = PAT ^ DW'($urandom_range(1, 4095));
        else
            data_i = PAT;

        flag = calibration_done_o | calibration_not_done_o;
        if (flag && !flag_q) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: done %0d not_done %0d", calibration_done_o,
                         calibration_not_done_o);
            end else begin
                e = sb_q.pop_front();
                chk("done", int'(calibration_done_o), e.done);
                chk("not_done", int'(calibration_not_done_o), e.nd);
                chk("eye_start", int'(eye_start_o), e.st);
                chk("eye_width", int'(eye_width_o), e.w);
                chk("final_tap", int'(idelay_tap_o), e.tap);
                chk("line", int'(idelay_line_o), e.line);
                chk("strobes", strobes - start_strobes, NT + 1);
                chk("sweep_cycles", cyc - first_cyc, SWEEP_CYC);
            end
        end
        flag_q = flag;
    end

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() > 0 && n < 2 * SWEEP_CYC) begin
            @(posedge clk_i);
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL sweep_timeout: no result after %0d cycles", n);
            sb_q.delete();
        end
    endtask

    task automatic run_sweep(input logic [31:0] m, input int line, input int gtap,
                             input int gsample, input bit hold_high);
        int base;
        mask = m;
        for (int t = 0; t < NT; t++) glitch[t] = $urandom_range(0, CHECK - 1);
        if (gtap >= 0) glitch[gtap] = gsample;
        model(m, line);
        start_strobes = strobes;
        first_tap = -1;
        @(negedge clk_i);
        line_sel_i = 8'(line);
        en_calib_i = 1'b1;
        wait_done();
        if (hold_high) begin
            base = strobes;
            repeat (150) @(posedge clk_i);
            #1;
            chk("hold_no_restart", strobes - base, 0);
            chk("hold_done", int'(calibration_done_o), 1);
        end
        @(negedge clk_i);
        en_calib_i = 1'b0;
        line_sel_i = 8'($urandom);
        repeat (3) @(posedge clk_i);
    endtask

    task automatic wait_for(input int tap, input int s, input string name);
        int n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!(cur_tap == tap && since == s) && n < 2 * SWEEP_CYC);
        if (n >= 2 * SWEEP_CYC) begin
            checks++; errors++;
            $display("FAIL %s_timeout: tap %0d not reached", name, tap);
        end
    endtask

    initial begin
        logic [31:0] m;
        int base;
        for (int t = 0; t < NT; t++) glitch[t] = 0;

        #3;
        chk("rst_ld", int'(idelay_ld_o), 0);
        chk("rst_tap", int'(idelay_tap_o), 0);
        chk("rst_line", int'(idelay_line_o), 0);
        chk("rst_done", int'(calibration_done_o), 0);
        chk("rst_not_done", int'(calibration_not_done_o), 0);
        chk("rst_eye_start", int'(eye_start_o), 0);
        chk("rst_eye_width", int'(eye_width_o), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);

        run_sweep(32'hFFFF_FFFF, 5, -1, 0, 1'b1);
        chk("first_strobe_tap", first_tap, 0);
        run_sweep(32'h0003_FC00, 7, -1, 0, 1'b0);
        run_sweep(32'h00F0_0078, 1, -1, 0, 1'b0);
        run_sweep(32'hE000_0000, 2, -1, 0, 1'b0);
        run_sweep(32'hFFFF_EFFF, 4, 12, CHECK - 1, 1'b0);

        for (int r = 0; r < 5; r++) begin
            int nruns, s, l;
            m = '0;
            nruns = $urandom_range(1, 3);
            for (int k = 0; k < nruns; k++) begin
                s = $urandom_range(0, NT - 1);
                l = $urandom_range(1, 12);
                for (int j = 0; j < l; j++) if (s + j < NT) m[s + j] = 1'b1;
            end
            run_sweep(m, $urandom_range(0, 255), -1, 0, 1'b0);
        end

        // Abort during the tap-7 check window, then restart from tap 0
        mask = 32'hFFFF_FFFF;
        start_strobes = strobes;
        @(negedge clk_i);
        line_sel_i = 8'd3;
        en_calib_i = 1'b1;
        wait_for(7, 30, "abort");
        @(negedge clk_i);
        en_calib_i = 1'b0;
        base = strobes;
        @(posedge clk_i);
        #1;
        chk("abort_ld", int'(idelay_ld_o), 0);
        chk("abort_done", int'(calibration_done_o), 0);
        repeat (100) @(posedge clk_i);
        #1;
        chk("abort_no_strobe", strobes - base, 0);
        chk("abort_not_done", int'(calibration_not_done_o), 0);
        chk("abort_tap_held", int'(idelay_tap_o), 7);
        run_sweep(32'hFFFF_FFFF, 3, -1, 0, 1'b0);
        chk("restart_first_tap", first_tap, 0);

        // Asynchronous reset in the middle of a settle interval
        start_strobes = strobes;
        @(negedge clk_i);
        line_sel_i = 8'd9;
        en_calib_i = 1'b1;
        wait_for(2, 5, "reset");
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_ld", int'(idelay_ld_o), 0);
        chk("arst_tap", int'(idelay_tap_o), 0);
        chk("arst_line", int'(idelay_line_o), 0);
        chk("arst_done", int'(calibration_done_o), 0);
        chk("arst_eye_width", int'(eye_width_o), 0);
        en_calib_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(posedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
